// File: rtl/debounce_pkg.sv
// Shared helpers for the button debouncer: width calculation and the
// seconds-to-cycles rounding used for every derived cycle count.
package debounce_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    longint unsigned v;
    w = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      w++;
    end
    return w;
  endfunction

  // Nearest whole cycle count, never below one.
  function automatic int unsigned cycle_count(input real freq, input real period);
    real    r;
    longint c;
    r = freq * period;
    c = $rtoi(r + 0.5);
    if (c < 1) return 1;
    return int'(c);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, stability counter, level and strobes.
// Optional long-press counter is built only when LONG_PRESS_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter logic        IdleLevel      = 1'b0,
  parameter int unsigned DebounceCycles = 1
`ifdef LONG_PRESS_EN
  ,
  parameter int unsigned HoldCycles     = 1
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic noisy_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int unsigned     CntW   = clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  synced;
  logic                  state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  press_q, press_d;
  logic                  rel_q, rel_d;

  assign synced = sync_q[SyncStages-1];

  always_comb begin
    sync_d  = {sync_q[SyncStages-2:0], noisy_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (synced == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      state_d = synced;
      cnt_d   = '0;
      press_d = (synced != IdleLevel);
      rel_d   = (synced == IdleLevel);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SyncStages{IdleLevel}};
      state_q <= IdleLevel;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned      HoldW    = clog2(HoldCycles + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HoldCycles);
  localparam logic [HoldW-1:0] HoldFire = HoldW'(HoldCycles - 1);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             hold_pulse_q, hold_pulse_d;

  // Saturating at HoldMax guarantees a single strobe per press.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    hold_pulse_d = 1'b0;
    if (state_q == IdleLevel) begin
      hold_cnt_d = '0;
    end else begin
      hold_pulse_d = (hold_cnt_q == HoldFire);
      if (hold_cnt_q != HoldMax) hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_q   <= '0;
      hold_pulse_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      hold_pulse_q <= hold_pulse_d;
    end
  end

  assign hold_o = hold_pulse_q;
`else
  assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/multi_btn_debouncer.sv
// Multi-channel button debouncer; one debounce_channel per input.
// Define LONG_PRESS_EN to enable per-channel long-press strobes.
module multi_btn_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned CLKIN_FREQ      = 27000000,
  parameter real         DEBOUNCE_PERIOD = 1e-3,
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        IDLE_LEVEL      = 1'b0,
  parameter real         HOLD_PERIOD     = 0.5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] noisyIn,
  output logic [NUM_CHANNELS-1:0] debounceOut,
  output logic [NUM_CHANNELS-1:0] pressPulse,
  output logic [NUM_CHANNELS-1:0] releasePulse,
  output logic [NUM_CHANNELS-1:0] holdPulse
);

  localparam int unsigned DebounceCycles = cycle_count(real'(CLKIN_FREQ), DEBOUNCE_PERIOD);
  localparam int unsigned HoldCycles     = cycle_count(real'(CLKIN_FREQ), HOLD_PERIOD);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .SyncStages     (SYNC_STAGES),
      .IdleLevel      (IDLE_LEVEL),
`ifdef LONG_PRESS_EN
      .HoldCycles     (HoldCycles),
`endif
      .DebounceCycles (DebounceCycles)
    ) u_chan (
      .clk_i     (clk),
      .rst_i     (reset),
      .noisy_i   (noisyIn[g]),
      .state_o   (debounceOut[g]),
      .press_o   (pressPulse[g]),
      .release_o (releasePulse[g]),
      .hold_o    (holdPulse[g])
    );
  end

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Scoreboard bench: stimulus queues expected strobe events, a negedge monitor
// pops and checks them against the observed strobes and their cycle.
module tb_multi_btn_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] noisyIn;
  logic [3:0] debounceOut, pressPulse, releasePulse, holdPulse;

  multi_btn_debouncer #(
    .CLKIN_FREQ      (1000),
    .DEBOUNCE_PERIOD (0.008),
    .NUM_CHANNELS    (4),
    .SYNC_STAGES     (2),
    .IDLE_LEVEL      (1'b0),
    .HOLD_PERIOD     (0.030)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .noisyIn      (noisyIn),
    .debounceOut  (debounceOut),
    .pressPulse   (pressPulse),
    .releasePulse (releasePulse),
    .holdPulse    (holdPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] hold;
    int         lo;
    int         hi;
    string      name;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe expected at cycle 'at' (sampled on the following negedge), +/-1.
  task automatic expect_ev(input string name, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] h, input int at);
    ev_t e;
    e.press = p;
    e.rel   = r;
    e.hold  = h;
    e.lo    = at - 1;
    e.hi    = at + 1;
    e.name  = name;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [11:0] obs;
    ev_t         e;
    obs = {pressPulse, releasePulse, holdPulse};
    if (obs != 12'h000) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got p=%b r=%b h=%b expected none (cycle %0d)",
                 pressPulse, releasePulse, holdPulse, cyc);
      end else begin
        e = q.pop_front();
        if (obs != {e.press, e.rel, e.hold} || cyc < e.lo || cyc > e.hi) begin
          fails++;
          $display("FAIL %s: got p=%b r=%b h=%b at cycle %0d expected p=%b r=%b h=%b in [%0d,%0d]",
                   e.name, pressPulse, releasePulse, holdPulse, cyc, e.press, e.rel, e.hold,
                   e.lo, e.hi);
        end
      end
    end
  end

  task automatic drain(input string name);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing: got %0d pending events expected 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    int c;
    reset   = 1'b1;
    noisyIn = 4'hF;
    step(1);
    // Reset held with all inputs pressed: everything stays quiet.
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("reset_outputs", {debounceOut, pressPulse, releasePulse, holdPulse}, 16'h0000);
    end
    reset = 1'b0;
    expect_ev("reset_release_press", 4'hF, 4'h0, 4'h0, cyc + 10);
    step(15);
    drain("reset_release");
    check("dout_after_reset", {12'h0, debounceOut}, 16'h000F);

    noisyIn = 4'h0;
    expect_ev("release_all", 4'h0, 4'hF, 4'h0, cyc + 10);
    step(15);
    drain("release_all");
    check("dout_idle", {12'h0, debounceOut}, 16'h0000);

    // 7-cycle glitch on ch0 must be rejected.
    noisyIn = 4'h1;
    step(7);
    noisyIn = 4'h0;
    step(15);
    check("glitch7_dout", {12'h0, debounceOut}, 16'h0000);

    // 9-cycle pulse on ch0 passes.
    c = cyc;
    noisyIn = 4'h1;
    expect_ev("pulse9_press", 4'h1, 4'h0, 4'h0, c + 10);
    expect_ev("pulse9_release", 4'h0, 4'h1, 4'h0, c + 19);
    step(9);
    noisyIn = 4'h0;
    step(20);
    drain("pulse9");

    // Bounce ch1 every 3 cycles, then settle high.
    for (int i = 0; i < 14; i++) begin
      noisyIn = (i % 2 == 0) ? 4'h2 : 4'h0;
      step(3);
    end
    noisyIn = 4'h2;
    expect_ev("bounce_press", 4'h2, 4'h0, 4'h0, cyc + 10);
    step(15);
    drain("bounce");
    check("bounce_dout", {12'h0, debounceOut}, 16'h0002);
    noisyIn = 4'h0;
    expect_ev("bounce_release", 4'h0, 4'h2, 4'h0, cyc + 10);
    step(15);
    drain("bounce_release");

    // Simultaneous press on ch2/ch3.
    noisyIn = 4'hC;
    expect_ev("simul_press", 4'hC, 4'h0, 4'h0, cyc + 10);
    step(15);
    drain("simul");
    check("simul_dout", {12'h0, debounceOut}, 16'h000C);
    noisyIn = 4'h0;
    expect_ev("simul_release", 4'h0, 4'hC, 4'h0, cyc + 10);
    step(15);
    drain("simul_release");

    // Reset mid-count: no strobe, then full latency from reset release.
    noisyIn = 4'h1;
    step(7);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("midreset_outputs", {debounceOut, pressPulse, releasePulse, holdPulse}, 16'h0000);
    end
    reset = 1'b0;
    expect_ev("midreset_press", 4'h1, 4'h0, 4'h0, cyc + 10);
    step(15);
    drain("midreset");
    noisyIn = 4'h0;
    expect_ev("midreset_release", 4'h0, 4'h1, 4'h0, cyc + 10);
    step(15);
    drain("midreset_release");

    // Long hold (50 cycles) then short hold (20 cycles) on ch0.
    c = cyc;
    noisyIn = 4'h1;
    expect_ev("long_press", 4'h1, 4'h0, 4'h0, c + 10);
`ifdef LONG_PRESS_EN
    expect_ev("long_hold", 4'h0, 4'h0, 4'h1, c + 40);
`endif
    expect_ev("long_release", 4'h0, 4'h1, 4'h0, c + 60);
    step(50);
    noisyIn = 4'h0;
    step(20);
    drain("long");

    c = cyc;
    noisyIn = 4'h1;
    expect_ev("short_press", 4'h1, 4'h0, 4'h0, c + 10);
    expect_ev("short_release", 4'h0, 4'h1, 4'h0, c + 30);
    step(20);
    noisyIn = 4'h0;
    step(50);
    drain("short");
    check("final_dout", {12'h0, debounceOut}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
